// File: rtl/clk_period_meter.sv
// clk_period_meter
//
// Measures the period of an asynchronous clock (meas_clk_i), in cycles of the
// reference clock clk_i. The measured clock is treated as data. It passes
// through a synchronizer and a history flop, and each detected rising edge
// becomes a one-cycle 'rise' pulse. The meter counts reference cycles from the
// first detected rise to the rise that closes edges_p periods.
//
// Ports
//   clk_i          reference clock (only clock domain)
//   reset_i        synchronous, active-high reset
//   meas_clk_i     clock under measurement, asynchronous to clk_i
//   start_v_i      request a measurement
//   start_ready_o  high only while idle
//   v_o            result valid
//   count_o        reference cycles spanned by edges_p measured periods
//   timeout_o      result aborted because no rise arrived in time
//   sat_o          count saturated at all-ones during the measurement
//   yumi_i         consumer takes the result
//
// Handshakes
//   Start:  a start is accepted on a cycle where start_v_i & start_ready_o.
//           start_v_i on any other cycle is ignored and is not queued.
//   Result: v_o stays high, with count_o/timeout_o/sat_o held, until the
//           cycle where yumi_i is high. yumi_i is only meaningful while v_o=1.
//           On the cycle after yumi_i, the meter is idle again.
//
// The FSM state is held in the named enum 'state' so that checkers can bind
// to it hierarchically.

module clk_period_meter #(
  parameter int sync_stages_p = 2,
  parameter int edges_p       = 16,
  parameter int count_width_p = 24,
  parameter int timeout_p     = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     meas_clk_i,
  input  logic                     start_v_i,
  output logic                     start_ready_o,
  output logic                     v_o,
  output logic [count_width_p-1:0] count_o,
  output logic                     timeout_o,
  output logic                     sat_o,
  input  logic                     yumi_i
);

  localparam int edge_w = $clog2(edges_p + 1);
  localparam int idle_w = $clog2(timeout_p);

  localparam logic [edge_w-1:0] edges_target = edge_w'(edges_p);
  // The abort fires on the rise-free cycle in which the idle timer would
  // reach timeout_p-1. That cycle is when the registered value is timeout_p-2.
  localparam logic [idle_w-1:0] idle_limit   = idle_w'(timeout_p - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Synchronizer and edge detector. The latency is the same for every edge,
  // so it cancels out of the first-to-last rise distance.
  logic [sync_stages_p-1:0] sync_r;
  logic                     hist_r;
  logic                     rise;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[sync_stages_p-2:0], meas_clk_i};
      hist_r <= sync_r[sync_stages_p-1];
    end
  end

  assign rise = sync_r[sync_stages_p-1] & ~hist_r;

  logic [edge_w-1:0] edges_r;
  logic [edge_w-1:0] edges_inc;
  logic [idle_w-1:0] idle_r;
  logic              count_full;

  assign edges_inc  = edges_r + edge_w'(1);
  assign count_full = (count_o == {count_width_p{1'b1}});

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      start_ready_o <= 1'b1;
      v_o           <= 1'b0;
      count_o       <= '0;
      timeout_o     <= 1'b0;
      sat_o         <= 1'b0;
      edges_r       <= '0;
      idle_r        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_v_i) begin
            state         <= ARM;
            start_ready_o <= 1'b0;
            count_o       <= '0;
            timeout_o     <= 1'b0;
            sat_o         <= 1'b0;
            edges_r       <= '0;
            idle_r        <= '0;
          end
        end

        ARM: begin
          if (rise) begin
            // The first detected rise is the time origin of the measurement.
            state   <= COUNT;
            count_o <= '0;
            edges_r <= '0;
            idle_r  <= '0;
          end else if (idle_r == idle_limit) begin
            state     <= DONE;
            v_o       <= 1'b1;
            timeout_o <= 1'b1;
            count_o   <= '0;
          end else begin
            idle_r <= idle_r + idle_w'(1);
          end
        end

        COUNT: begin
          // sat_o marks an increment that was lost at all-ones. It does not
          // mark a count that only landed exactly on all-ones.
          if (count_full) begin
            sat_o <= 1'b1;
          end else begin
            count_o <= count_o + count_width_p'(1);
          end

          // A rise takes priority over a timeout in the same cycle.
          if (rise) begin
            idle_r  <= '0;
            edges_r <= edges_inc;
            if (edges_inc == edges_target) begin
              state <= DONE;
              v_o   <= 1'b1;
            end
          end else if (idle_r == idle_limit) begin
            state     <= DONE;
            v_o       <= 1'b1;
            timeout_o <= 1'b1;
          end else begin
            idle_r <= idle_r + idle_w'(1);
          end
        end

        DONE: begin
          if (yumi_i) begin
            state         <= IDLE;
            v_o           <= 1'b0;
            start_ready_o <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          v_o           <= 1'b0;
          start_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter.
//
// The bench drives the measured clock from a small behavioural generator with
// programmable high/low phase lengths, counted in reference cycles. The
// generator changes meas_clk on the falling reference edge.
//
// The expected results come from the rules, not from the RTL:
//   - N measured periods of length P give a count of N*P.
//   - The count clips at 2^W-1, and sat is set whenever N*P exceeds 2^W-1.
//   - If the clock stops after the last rise, the count is the rise distance
//     plus timeout-1 rise-free cycles.
//
// Two instances are used: dut0 (24-bit count) and dut1 (6-bit count).
// Both have timeout 64.

module tb_clk_period_meter;

  localparam int TO  = 64;
  localparam int EP  = 16;
  localparam int CW0 = 24;
  localparam int CW1 = 6;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic meas_clk = 1'b0;

  logic           start_v0 = 1'b0;
  logic           yumi0    = 1'b0;
  logic           ready0, v0, to0, sat0;
  logic [CW0-1:0] count0;

  logic           start_v1 = 1'b0;
  logic           yumi1    = 1'b0;
  logic           ready1, v1, to1, sat1;
  logic [CW1-1:0] count1;

  int checks   = 0;
  int failures = 0;

  // Measured-clock generator controls.
  bit meas_run  = 1'b0;
  int meas_hi   = 5;
  int meas_lo   = 5;
  int meas_stop = 0;  // 0 = free-running, otherwise stop low after this many rises
  int ph        = 0;
  int rises     = 0;

  clk_period_meter #(
    .sync_stages_p(2), .edges_p(EP), .count_width_p(CW0), .timeout_p(TO)
  ) dut0 (
    .clk_i(clk), .reset_i(reset), .meas_clk_i(meas_clk),
    .start_v_i(start_v0), .start_ready_o(ready0), .v_o(v0),
    .count_o(count0), .timeout_o(to0), .sat_o(sat0), .yumi_i(yumi0)
  );

  clk_period_meter #(
    .sync_stages_p(2), .edges_p(EP), .count_width_p(CW1), .timeout_p(TO)
  ) dut1 (
    .clk_i(clk), .reset_i(reset), .meas_clk_i(meas_clk),
    .start_v_i(start_v1), .start_ready_o(ready1), .v_o(v1),
    .count_o(count1), .timeout_o(to1), .sat_o(sat1), .yumi_i(yumi1)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural generator of the measured clock.
  always @(negedge clk) begin
    if (!meas_run) begin
      meas_clk = 1'b0;
      ph       = 0;
      rises    = 0;
    end else if (meas_stop != 0 && rises >= meas_stop && !meas_clk) begin
      meas_clk = 1'b0;
    end else begin
      ph++;
      if (meas_clk && ph >= meas_hi) begin
        meas_clk = 1'b0;
        ph       = 0;
      end else if (!meas_clk && ph >= meas_lo) begin
        meas_clk = 1'b1;
        ph       = 0;
        rises++;
      end
    end
  end

  // Driver tasks
  task automatic set_clock(input int hi, input int lo, input int stop);
    meas_run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    meas_hi   = hi;
    meas_lo   = lo;
    meas_stop = stop;
    meas_run  = (hi > 0);
  endtask

  task automatic start0();
    start_v0 = 1'b1;
    @(posedge clk);
    #1;
    start_v0 = 1'b0;
  endtask

  task automatic wait_v0(input int limit, output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    while (!got && lat < limit) begin
      @(posedge clk);
      #1;
      lat++;
      if (v0) got = 1'b1;
    end
  endtask

  task automatic yumi0_pulse();
    yumi0 = 1'b1;
    @(posedge clk);
    #1;
    yumi0 = 1'b0;
  endtask

  task automatic run_meas0(output logic [CW0-1:0] cnt, output logic to,
                           output logic sat, output int lat, output bit got);
    start0();
    wait_v0(3000, lat, got);
    cnt = count0;
    to  = to0;
    sat = sat0;
    if (got) yumi0_pulse();
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready0: got %b want 1", ready0); end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL reset_v0: got %b want 0", v0); end
    checks++; if (count0 !== '0) begin failures++; $display("FAIL reset_count0: got %0d want 0", count0); end
    checks++; if ({to0, sat0} !== 2'b00) begin failures++; $display("FAIL reset_flags0: got %b want 00", {to0, sat0}); end
    checks++; if ({ready1, v1, to1, sat1} !== 4'b1000) begin failures++; $display("FAIL reset_dut1: got %b want 1000", {ready1, v1, to1, sat1}); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ready0, v0} !== 2'b10) begin failures++; $display("FAIL post_reset0: got %b want 10", {ready0, v0}); end
  endtask

  task automatic test_basic();
    logic [CW0-1:0] cnt;
    logic to, sat;
    int lat;
    bit got;
    set_clock(5, 5, 0);
    run_meas0(cnt, to, sat, lat, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", got); end
    checks++; if (cnt !== 24'(EP * 10)) begin failures++; $display("FAIL basic_count: got %0d want %0d", cnt, EP * 10); end
    checks++; if ({to, sat} !== 2'b00) begin failures++; $display("FAIL basic_flags: got %b want 00", {to, sat}); end
    checks++; if ({ready0, v0} !== 2'b10) begin failures++; $display("FAIL basic_after_yumi: got %b want 10", {ready0, v0}); end
  endtask

  // Generator select 0..3, each step doubling a base period of 4.
  task automatic test_select_sweep();
    logic [CW0-1:0] cnt;
    logic to, sat;
    int lat, p;
    bit got;
    for (int sel = 0; sel < 4; sel++) begin
      p = 4 << sel;
      set_clock(p / 2, p / 2, 0);
      run_meas0(cnt, to, sat, lat, got);
      checks++; if (got !== 1'b1 || cnt !== 24'(EP * p)) begin failures++; $display("FAIL sweep_sel%0d: got %0d want %0d (valid %b)", sel, cnt, EP * p, got); end
      checks++; if ({to, sat} !== 2'b00) begin failures++; $display("FAIL sweep_flags_sel%0d: got %b want 00", sel, {to, sat}); end
    end
  endtask

  task automatic test_random_periods();
    logic [CW0-1:0] cnt;
    logic to, sat;
    int lat, p, hi;
    bit got;
    for (int i = 0; i < 6; i++) begin
      p  = $urandom_range(4, 40);
      hi = $urandom_range(2, p - 2);
      set_clock(hi, p - hi, 0);
      repeat ($urandom_range(0, p)) @(posedge clk);
      #1;
      run_meas0(cnt, to, sat, lat, got);
      checks++; if (got !== 1'b1 || cnt !== 24'(EP * p)) begin failures++; $display("FAIL rand_count p=%0d hi=%0d: got %0d want %0d", p, hi, cnt, EP * p); end
      checks++; if ({to, sat} !== 2'b00) begin failures++; $display("FAIL rand_flags p=%0d: got %b want 00", p, {to, sat}); end
    end
  endtask

  task automatic test_timeout_idle();
    logic [CW0-1:0] cnt;
    logic to, sat;
    int lat;
    bit got;
    set_clock(0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    run_meas0(cnt, to, sat, lat, got);
    checks++; if (got !== 1'b1 || lat < TO - 1 || lat > TO + 2) begin failures++; $display("FAIL timeout_latency: got %0d cycles (valid %b) want %0d..%0d", lat, got, TO - 1, TO + 2); end
    checks++; if (to !== 1'b1) begin failures++; $display("FAIL timeout_flag: got %b want 1", to); end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL timeout_count: got %0d want 0", cnt); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL timeout_sat: got %b want 0", sat); end
  endtask

  // Six rises (first + 5 periods), then the clock stops low.
  task automatic test_timeout_stopped();
    logic [CW0-1:0] cnt;
    logic to, sat;
    int lat, p, hi, exp_cnt;
    bit got;
    p  = $urandom_range(6, 20);
    hi = p / 2;
    exp_cnt = 5 * p + (TO - 1);
    set_clock(hi, p - hi, 6);
    run_meas0(cnt, to, sat, lat, got);
    checks++; if (got !== 1'b1 || to !== 1'b1) begin failures++; $display("FAIL stopped_flag: got to=%b valid=%b want 1", to, got); end
    checks++; if (cnt !== 24'(exp_cnt)) begin failures++; $display("FAIL stopped_count p=%0d: got %0d want %0d", p, cnt, exp_cnt); end
  endtask

  task automatic test_saturation();
    logic [CW1-1:0] exp_q[$];
    int lat, p;
    bit got;
    int sat_exp;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? 10 : $urandom_range(4, 30);
      exp_q.push_back(((EP * p) > 63) ? 6'd63 : 6'(EP * p));
      sat_exp = ((EP * p) > 63) ? 1 : 0;
      set_clock(p / 2, p - p / 2, 0);
      start_v1 = 1'b1;
      @(posedge clk);
      #1;
      start_v1 = 1'b0;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 3000) begin
        @(posedge clk);
        #1;
        lat++;
        if (v1) got = 1'b1;
      end
      checks++; if (got !== 1'b1 || count1 !== exp_q[0]) begin failures++; $display("FAIL sat_count p=%0d: got %0d want %0d (valid %b)", p, count1, exp_q[0], got); end
      checks++; if (sat1 !== 1'(sat_exp) || to1 !== 1'b0) begin failures++; $display("FAIL sat_flags p=%0d: got sat=%b to=%b want sat=%0d to=0", p, sat1, to1, sat_exp); end
      void'(exp_q.pop_front());
      yumi1 = 1'b1;
      @(posedge clk);
      #1;
      yumi1 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [CW0-1:0] cnt;
    logic to, sat;
    int lat;
    bit got;
    int bad;
    set_clock(5, 5, 0);
    start0();
    wait_v0(3000, lat, got);
    checks++; if (got !== 1'b1 || count0 !== 24'(EP * 10)) begin failures++; $display("FAIL hold_first: got %0d want %0d (valid %b)", count0, EP * 10, got); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      start_v0 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (v0 !== 1'b1 || ready0 !== 1'b0 || count0 !== 24'(EP * 10) || to0 !== 1'b0 || sat0 !== 1'b0) bad++;
    end
    start_v0 = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
    yumi0_pulse();
    checks++; if ({v0, ready0} !== 2'b01) begin failures++; $display("FAIL hold_yumi_idle: got v/ready=%b want 01", {v0, ready0}); end
    checks++; if (count0 !== 24'(EP * 10)) begin failures++; $display("FAIL hold_count_kept: got %0d want %0d", count0, EP * 10); end
    set_clock(4, 4, 0);
    run_meas0(cnt, to, sat, lat, got);
    checks++; if (got !== 1'b1 || cnt !== 24'(EP * 8)) begin failures++; $display("FAIL hold_next: got %0d want %0d", cnt, EP * 8); end
  endtask

  task automatic test_reset_mid_count();
    logic [CW0-1:0] cnt;
    logic to, sat;
    int lat;
    bit got;
    set_clock(5, 5, 0);
    start0();
    repeat (40) @(posedge clk);
    #1;
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL midrst_precond: got v=%b want 0", v0); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if ({ready0, v0, to0, sat0} !== 4'b1000 || count0 !== '0) begin failures++; $display("FAIL midrst_state: got rvts=%b count=%0d want 1000 count=0", {ready0, v0, to0, sat0}, count0); end
    repeat (5) @(posedge clk);
    #1;
    run_meas0(cnt, to, sat, lat, got);
    checks++; if (got !== 1'b1 || cnt !== 24'(EP * 10) || to !== 1'b0) begin failures++; $display("FAIL midrst_fresh: got %0d to=%b want %0d to=0", cnt, to, EP * 10); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_select_sweep();
    test_random_periods();
    test_timeout_idle();
    test_timeout_stopped();
    test_saturation();
    test_back_to_back();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
